// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice.
//   op_e     : 4-bit opcode encoding, ADD=0 .. SHR=9; 10..15 are illegal.
//   state_t  : arbiter FSM state type with ST_IDLE / ST_EXEC / ST_RESP.
//   hex7     : hex digit to seven-segment (gfedcba, active high) decoder
//              used by the ALU display outputs.
// -----------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_MUL = 4'd2,
      OP_DIV = 4'd3,
      OP_MOD = 4'd4,
      OP_AND = 4'd5,
      OP_OR  = 4'd6,
      OP_XOR = 4'd7,
      OP_SHL = 4'd8,
      OP_SHR = 4'd9
   } op_e;

   // Highest legal opcode; anything above is rejected by the arbiter.
   localparam logic [3:0] OP_LAST = 4'd9;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_EXEC = 2'd1;
   localparam state_t ST_RESP = 2'd2;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] seg;
      case (v)
         4'h0:    seg = 7'b0111111;
         4'h1:    seg = 7'b0000110;
         4'h2:    seg = 7'b1011011;
         4'h3:    seg = 7'b1001111;
         4'h4:    seg = 7'b1100110;
         4'h5:    seg = 7'b1101101;
         4'h6:    seg = 7'b1111101;
         4'h7:    seg = 7'b0000111;
         4'h8:    seg = 7'b1111111;
         4'h9:    seg = 7'b1101111;
         4'ha:    seg = 7'b1110111;
         4'hb:    seg = 7'b1111100;
         4'hc:    seg = 7'b0111001;
         4'hd:    seg = 7'b1011110;
         4'he:    seg = 7'b1111001;
         default: seg = 7'b1110001;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// -----------------------------------------------------------------------------
// alu_arbiter_alu
// Purely combinational n-bit ALU.
//   a_i, b_i   : unsigned operands (n bits)
//   op_i       : opcode (alu_pkg::op_e encoding)
//   result_o   : 2n-bit result. MUL gives the full product; every other
//                operation gives an n-bit value zero-extended.
//   flags_o    : {N,Z,C,V}
//                N = MSB of the meaningful width (bit 2n-1 for MUL, else n-1)
//                Z = whole 2n-bit result is zero
//                C = ADD carry-out, SUB borrow (a<b), MUL high half non-zero,
//                    0 otherwise
//                V = signed overflow for ADD/SUB, 0 otherwise
//   seg_lo_o   : seven-segment image of result bits [3:0]
//   seg_hi_o   : seven-segment image of the top result nibble
// Division or modulo by zero and illegal opcodes yield zero here; rejecting
// them is the arbiter's job.
// -----------------------------------------------------------------------------
module alu_arbiter_alu
   import alu_pkg::*;
#(
   parameter int n = 4
) (
   input  logic [n-1:0]   a_i,
   input  logic [n-1:0]   b_i,
   input  logic [3:0]     op_i,
   output logic [2*n-1:0] result_o,
   output logic [3:0]     flags_o,
   output logic [6:0]     seg_lo_o,
   output logic [6:0]     seg_hi_o
);

   logic [n:0]     sum;
   logic [n:0]     diff;
   logic [2*n-1:0] prod;
   logic [n-1:0]   quot;
   logic [n-1:0]   rem;
   logic [n-1:0]   narrow;
   logic [2*n-1:0] result;
   logic           is_mul;
   logic           flag_n;
   logic           flag_c;
   logic           flag_v;

   assign sum  = {1'b0, a_i} + {1'b0, b_i};
   // Extra top bit of the widened difference is the borrow.
   assign diff = {1'b0, a_i} - {1'b0, b_i};
   assign prod = {{n{1'b0}}, a_i} * {{n{1'b0}}, b_i};
   assign quot = (b_i == '0) ? '0 : a_i / b_i;
   assign rem  = (b_i == '0) ? '0 : a_i % b_i;

   always_comb begin
      narrow = '0;
      is_mul = 1'b0;
      flag_c = 1'b0;
      flag_v = 1'b0;
      case (op_i)
         OP_ADD: begin
            narrow = sum[n-1:0];
            flag_c = sum[n];
            flag_v = (a_i[n-1] == b_i[n-1]) && (sum[n-1] != a_i[n-1]);
         end
         OP_SUB: begin
            narrow = diff[n-1:0];
            flag_c = diff[n];
            flag_v = (a_i[n-1] != b_i[n-1]) && (diff[n-1] != a_i[n-1]);
         end
         OP_MUL: begin
            is_mul = 1'b1;
            flag_c = |prod[2*n-1:n];
         end
         OP_DIV:  narrow = quot;
         OP_MOD:  narrow = rem;
         OP_AND:  narrow = a_i & b_i;
         OP_OR:   narrow = a_i | b_i;
         OP_XOR:  narrow = a_i ^ b_i;
         OP_SHL:  narrow = a_i << b_i;
         OP_SHR:  narrow = a_i >> b_i;
         default: narrow = '0;
      endcase
      result = is_mul ? prod : {{n{1'b0}}, narrow};
      flag_n = is_mul ? result[2*n-1] : result[n-1];
   end

   assign result_o = result;
   assign flags_o  = {flag_n, (result == '0), flag_c, flag_v};
   assign seg_lo_o = hex7(result[3:0]);
   assign seg_hi_o = hex7(result[2*n-1 -: 4]);

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Two-requester round-robin front end for a single shared ALU.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req0_* / req1_*             : request channels (valid, ready, a, b, op)
//   rsp_valid / rsp_ready       : response handshake
//   rsp_id                      : which requester owns the response
//   rsp_result, rsp_flags       : captured ALU result and {N,Z,C,V}
//   rsp_err                     : illegal opcode or DIV/MOD by zero
//   dbg_state_o                 : current FSM state (alu_pkg::state_t)
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both 1. The arbiter raises at most one reqX_ready, only in IDLE,
// only for a requester whose valid is high, and never during reset. The
// response is held unchanged while rsp_valid=1 until rsp_ready=1 is sampled.
//
// Flow: IDLE --accept--> EXEC --(1 cycle)--> RESP --rsp_ready--> IDLE
// -----------------------------------------------------------------------------
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [N-1:0]   req0_a,
   input  logic [N-1:0]   req0_b,
   input  logic [3:0]     req0_op,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [N-1:0]   req1_a,
   input  logic [N-1:0]   req1_b,
   input  logic [3:0]     req1_op,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [2*N-1:0] rsp_result,
   output logic [3:0]     rsp_flags,
   output logic           rsp_err,
   output logic [1:0]     dbg_state_o
);

   state_t         state_q;
   state_t         state_d;
   logic           last_q;
   logic [N-1:0]   a_q;
   logic [N-1:0]   b_q;
   logic [3:0]     op_q;
   logic           id_q;
   logic           rsp_valid_q;
   logic           rsp_id_q;
   logic           rsp_err_q;
   logic [2*N-1:0] rsp_result_q;
   logic [3:0]     rsp_flags_q;

   logic           grant_valid;
   logic           grant_id;
   logic           op_err;
   logic [2*N-1:0] alu_result;
   logic [3:0]     alu_flags;

   // Grant selection. last_q holds the index granted most recently, so on
   // contention the other requester wins. Gated by rst_n so no ready leaks
   // out while the block is held in reset.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      if (rst_n && (state_q == ST_IDLE)) begin
         if (req0_valid && req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = ~last_q;
         end else if (req0_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
         end else if (req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
         end
      end
   end

   assign req0_ready = grant_valid & ~grant_id;
   assign req1_ready = grant_valid &  grant_id;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (grant_valid) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand capture and grant history; both change only on an accept, so
   // requester activity after the handshake cannot disturb the operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         id_q   <= 1'b0;
         last_q <= 1'b1;
      end else if (grant_valid) begin
         a_q    <= grant_id ? req1_a  : req0_a;
         b_q    <= grant_id ? req1_b  : req0_b;
         op_q   <= grant_id ? req1_op : req0_op;
         id_q   <= grant_id;
         last_q <= grant_id;
      end
   end

   alu_arbiter_alu #(
      .n (N)
   ) u_alu (
      .a_i      (a_q),
      .b_i      (b_q),
      .op_i     (op_q),
      .result_o (alu_result),
      .flags_o  (alu_flags),
      .seg_lo_o (),
      .seg_hi_o ()
   );

   assign op_err = (op_q > OP_LAST) ||
                   (((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_q == '0));

   // Response capture at the end of EXEC; held through RESP until taken.
   // Only rsp_valid drops on the take; the data registers keep their value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
      end else if (state_q == ST_EXEC) begin
         rsp_valid_q  <= 1'b1;
         rsp_id_q     <= id_q;
         rsp_err_q    <= op_err;
         rsp_result_q <= op_err ? '0 : alu_result;
         rsp_flags_q  <= op_err ? '0 : alu_flags;
      end else if ((state_q == ST_RESP) && rsp_ready) begin
         rsp_valid_q  <= 1'b0;
      end
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_flags   = rsp_flags_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter (N=4). Expected responses come from an
// arithmetic reference model (plain integer maths on the operation rules) and
// a round-robin grant model; expected responses are queued in exp_q.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int N = 4;
   localparam int W = 2*N + 6;   // {id, err, flags[3:0], result[2N-1:0]}

   logic           clk;
   logic           rst_n;
   logic           req0_valid, req1_valid;
   logic           req0_ready, req1_ready;
   logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
   logic [3:0]     req0_op, req1_op;
   logic           rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [2*N-1:0] rsp_result;
   logic [3:0]     rsp_flags;
   logic [1:0]     dbg_state;

   int             checks = 0;
   int             errors = 0;
   int             last_id = 1;
   logic [W-1:0]   exp_q[$];

   alu_arbiter #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_op     (req0_op),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_op     (req1_op),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_result  (rsp_result),
      .rsp_flags   (rsp_flags),
      .rsp_err     (rsp_err),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: operation rules in integer arithmetic.
   function automatic logic [W-1:0] model(input int id, input int op, input int a, input int b);
      int m;
      int r;
      int sa, sb, sr;
      bit fn, fz, fc, fv, err;
      logic [31:0] rv;
      logic [31:0] idv;
      m  = 1 << N;
      sa = (a >= m/2) ? a - m : a;
      sb = (b >= m/2) ? b - m : b;
      err = (op > 9) || (((op == 3) || (op == 4)) && (b == 0));
      r = 0; fc = 0; fv = 0;
      case (op)
         0: begin r = (a + b) % m; fc = (a + b) >= m; sr = sa + sb; fv = (sr >= m/2) || (sr < -m/2); end
         1: begin r = (a - b + m) % m; fc = a < b; sr = sa - sb; fv = (sr >= m/2) || (sr < -m/2); end
         2: begin r = a * b; fc = r >= m; end
         3: r = (b != 0) ? a / b : 0;
         4: r = (b != 0) ? a % b : 0;
         5: r = a & b;
         6: r = a | b;
         7: r = a ^ b;
         8: r = (a << b) % m;
         9: r = a >> b;
         default: r = 0;
      endcase
      fn = (op == 2) ? (r >= (m*m)/2) : (r >= m/2);
      fz = (r == 0);
      if (err) begin
         r = 0; fn = 0; fz = 0; fc = 0; fv = 0;
      end
      rv  = r;
      idv = id;
      return {idv[0], err, fn, fz, fc, fv, rv[2*N-1:0]};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      rst_n      = 1'b0;
      @(posedge clk); #1;
      rst_n   = 1'b1;
      last_id = 1;
   endtask

   // One complete transaction starting in IDLE at posedge+1.
   task automatic run_txn(input bit v0, input bit v1,
                          input int op0, input int a0, input int b0,
                          input int op1, input int a1, input int b1,
                          input int hold, output int g);
      logic [W-1:0] cur;
      req0_valid = v0; req0_op = 4'(op0); req0_a = N'(a0); req0_b = N'(b0);
      req1_valid = v1; req1_op = 4'(op1); req1_a = N'(a1); req1_b = N'(b1);
      rsp_ready  = 1'b0;
      #1;
      g = (v0 && v1) ? (1 - last_id) : (v0 ? 0 : 1);
      chk("ready0", 32'(req0_ready), 32'(g == 0));
      chk("ready1", 32'(req1_ready), 32'(g == 1));
      exp_q.push_back((g == 0) ? model(0, op0, a0, b0) : model(1, op1, a1, b1));
      last_id = g;
      @(posedge clk); #1;
      chk("exec_state", 32'(dbg_state), 32'(ST_EXEC));
      chk("exec_no_rsp", 32'(rsp_valid), 32'(0));
      chk("exec_readys", 32'({req0_ready, req1_ready}), 32'(0));
      // Disturb the accepted requester's inputs; must not leak into result.
      if (g == 0) begin
         req0_a = N'($urandom_range(0, (1 << N) - 1));
         req0_b = N'($urandom_range(0, (1 << N) - 1));
         req0_op = 4'($urandom_range(0, 15));
      end else begin
         req1_a = N'($urandom_range(0, (1 << N) - 1));
         req1_b = N'($urandom_range(0, (1 << N) - 1));
         req1_op = 4'($urandom_range(0, 15));
      end
      @(posedge clk); #1;
      chk("rsp_valid", 32'(rsp_valid), 32'(1));
      cur = exp_q.pop_front();
      chk("rsp_fields", 32'({rsp_id, rsp_err, rsp_flags, rsp_result}), 32'(cur));
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         chk("hold_rsp", 32'({rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result}), 32'({1'b1, cur}));
         chk("hold_readys", 32'({req0_ready, req1_ready}), 32'(0));
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_drop", 32'(rsp_valid), 32'(0));
      chk("back_idle", 32'(dbg_state), 32'(ST_IDLE));
   endtask

   // ---------------- directed and random sequence ----------------
   initial begin
      int g;
      int op, v;
      bit r0, r1;
      req0_a = '0; req0_b = '0; req0_op = '0;
      req1_a = '0; req1_b = '0; req1_op = '0;
      rsp_ready  = 1'b0;
      rst_n      = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #3;
      chk("reset_readys", 32'({req0_ready, req1_ready}), 32'(0));
      chk("reset_rsp", 32'({rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result}), 32'(0));
      chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
      @(posedge clk); #1;
      do_reset();

      // ADD 7+9 -> 0 with Z and C set
      run_txn(1, 0, 0, 7, 9, 0, 0, 0, 0, g);
      chk("add_fields", 32'({rsp_id, rsp_err, rsp_flags, rsp_result}), 32'({1'b0, 1'b0, 4'b0110, 8'h00}));

      // contention after reset: req0 MUL first, then req1 SUB
      do_reset();
      run_txn(1, 1, 2, 3, 5, 1, 2, 5, 0, g);
      chk("first_grant", 32'(g), 32'(0));
      chk("mul_result", 32'(rsp_result), 32'(8'h0F));
      run_txn(1, 1, 2, 3, 5, 1, 2, 5, 0, g);
      chk("second_grant", 32'(g), 32'(1));
      chk("sub_result", 32'({rsp_id, rsp_result, rsp_flags[3]}), 32'({1'b1, 8'h0D, 1'b1}));

      // divide by zero, then a legal divide
      run_txn(0, 1, 0, 0, 0, 3, 6, 0, 0, g);
      chk("div0_err", 32'({rsp_err, rsp_flags, rsp_result}), 32'({1'b1, 4'b0000, 8'h00}));
      run_txn(0, 1, 0, 0, 0, 3, 6, 2, 0, g);
      chk("div_ok", 32'({rsp_err, rsp_result}), 32'({1'b0, 8'h03}));

      // consumer stall for 5 cycles
      run_txn(1, 0, 5, 12, 10, 0, 0, 0, 5, g);

      // illegal opcode
      run_txn(1, 0, 15, 3, 4, 0, 0, 0, 0, g);
      chk("illegal_op", 32'({rsp_err, rsp_result}), 32'({1'b1, 8'h00}));

      // continuous contention: grants alternate starting at 0
      do_reset();
      for (int k = 0; k < 6; k++) begin
         run_txn(1, 1, $urandom_range(0, 9), $urandom_range(0, 15), $urandom_range(1, 15),
                 $urandom_range(0, 9), $urandom_range(0, 15), $urandom_range(1, 15), 0, g);
         chk("alt_grant", 32'(g), 32'(k % 2));
      end

      // reset asserted while an operation is in EXEC
      req0_valid = 1'b1; req0_op = 4'd0; req0_a = 4'd1; req0_b = 4'd2;
      req1_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre_reset_exec", 32'(dbg_state), 32'(ST_EXEC));
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_exec_outputs", 32'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result}), 32'(0));
      req0_valid = 1'b0;
      @(posedge clk); #1;
      rst_n   = 1'b1;
      last_id = 1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("no_rsp_after_reset", 32'(rsp_valid), 32'(0));
      end

      // randomized traffic
      for (int k = 0; k < 24; k++) begin
         v  = $urandom_range(1, 3);
         r0 = v[0];
         r1 = v[1];
         op = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
         run_txn(r0, r1, op, $urandom_range(0, 15), $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 2), g);
      end

      chk("queue_empty", 32'(exp_q.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
